// File: rtl/core_pkg.sv
// Core-wide types shared between pipeline units: PC width and the EXU branch
// resolution packet carried on the ex_rsp interface.
package core_pkg;

  localparam int RV_PC_SIZE = 32;

  typedef struct packed {
    logic [RV_PC_SIZE-1:0] pc;
    logic [RV_PC_SIZE-1:0] target_pc;
    logic                  taken;
    logic                  pred_true;
  } ex_rsp_pkt_t;

endpackage

// File: rtl/ifu_branch_resolver_pkg.sv
// IFU branch-resolution types: resolver FSM states, the 2-bit BHT counter
// and its saturating update rule.
package ifu_branch_resolver_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REDIRECT
  } ifu_br_state_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;

  function automatic bht_ctr_t bht_sat_update(bht_ctr_t ctr, logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'd1;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ex_rsp_if_t.sv
// EXU -> IFU branch resolution channel; the EXU branch handler is master,
// the IFU branch resolver is slave.
interface ex_rsp_if_t;
  import core_pkg::*;

  logic        vld;
  logic        rdy;
  ex_rsp_pkt_t pkt;

  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);

endinterface

// File: rtl/ifu_bht.sv
// Bimodal branch history table: 2-bit saturating counters with an
// asynchronous read port (returns pre-write data) and one update port.
module ifu_bht
  import ifu_branch_resolver_pkg::*;
#(
  parameter int BHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 wr_en,
  input  logic [BHT_IDX_W-1:0] wr_idx,
  input  logic                 wr_taken
);

  localparam int ENTRIES = 1 << BHT_IDX_W;

  bht_ctr_t ctrs [ENTRIES];

  // Reset rewrites every entry so a mid-run reset restores weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctrs[i] <= BHT_INIT;
      end
    end else if (wr_en) begin
      ctrs[wr_idx] <= bht_sat_update(ctrs[wr_idx], wr_taken);
    end
  end

  assign rd_taken = ctrs[rd_idx][1];

endmodule

// File: rtl/ifu_branch_resolver.sv
// Consumes EXU branch resolutions, trains the BHT, and on a misprediction
// flushes fetch, drains wrong-path fetches and issues one PC redirect.
module ifu_branch_resolver
  import core_pkg::*;
  import ifu_branch_resolver_pkg::*;
#(
  parameter int BHT_IDX_W       = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ex_rsp_if_t.slv               ex_rsp_slv,
  input  logic [RV_PC_SIZE-1:0] pred_pc,
  output logic                  pred_taken,
  input  logic                  fch_req_fire,
  input  logic                  fch_rsp_fire,
  output logic                  fch_req_allow,
  output logic                  fch_rsp_drop,
  output logic                  flush,
  output logic                  redir_vld,
  input  logic                  redir_rdy,
  output logic [RV_PC_SIZE-1:0] redir_pc
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  ifu_br_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             mispredict_accept;
  logic             unused_pc_bits;

  assign ex_rsp_slv.rdy    = (state == IDLE);
  assign accept            = ex_rsp_slv.vld && ex_rsp_slv.rdy;
  assign mispredict_accept = accept && !ex_rsp_slv.pkt.pred_true;

  assign flush         = mispredict_accept;
  assign fch_req_allow = (state == IDLE) && !mispredict_accept &&
                         (cnt < CNT_W'(MAX_OUTSTANDING));
  assign fch_rsp_drop  = (state != IDLE) || mispredict_accept;

  ifu_bht #(
    .BHT_IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pred_pc[BHT_IDX_W+1:2]),
    .rd_taken (pred_taken),
    .wr_en    (accept),
    .wr_idx   (ex_rsp_slv.pkt.pc[BHT_IDX_W+1:2]),
    .wr_taken (ex_rsp_slv.pkt.taken)
  );

  // PC bits outside the BHT index do not participate in prediction.
  assign unused_pc_bits = ^{pred_pc[RV_PC_SIZE-1:BHT_IDX_W+2], pred_pc[1:0],
                            ex_rsp_slv.pkt.pc[RV_PC_SIZE-1:BHT_IDX_W+2],
                            ex_rsp_slv.pkt.pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (fch_req_fire && !fch_rsp_fire) begin
      cnt <= cnt + CNT_W'(1);
    end else if (fch_rsp_fire && !fch_req_fire) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      redir_vld <= 1'b0;
      redir_pc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict_accept) begin
            redir_pc <= ex_rsp_slv.pkt.target_pc;
            state    <= DRAIN;
          end
        end
        // Waits on the registered count, so DRAIN always lasts a cycle.
        DRAIN: begin
          if (cnt == '0) begin
            redir_vld <= 1'b1;
            state     <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redir_rdy) begin
            redir_vld <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          redir_vld <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fch_rsp_fire && !fch_req_fire && cnt == '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fch_req_fire && !fch_rsp_fire && cnt == CNT_W'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_ifu_branch_resolver.sv
// Randomized + directed bench for ifu_branch_resolver; a behavioural model
// queues expected outputs per cycle and a monitor compares them.
module tb_ifu_branch_resolver;
  import core_pkg::*;

  localparam int MAX_OUT = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [RV_PC_SIZE-1:0] pred_pc;
  logic                  pred_taken;
  logic                  fch_req_fire;
  logic                  fch_rsp_fire;
  logic                  fch_req_allow;
  logic                  fch_rsp_drop;
  logic                  flush;
  logic                  redir_vld;
  logic                  redir_rdy;
  logic [RV_PC_SIZE-1:0] redir_pc;

  ex_rsp_if_t ex_rsp ();

  ifu_branch_resolver #(
    .BHT_IDX_W       (6),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_rsp_slv    (ex_rsp),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .fch_req_fire  (fch_req_fire),
    .fch_rsp_fire  (fch_rsp_fire),
    .fch_req_allow (fch_req_allow),
    .fch_rsp_drop  (fch_rsp_drop),
    .flush         (flush),
    .redir_vld     (redir_vld),
    .redir_rdy     (redir_rdy),
    .redir_pc      (redir_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pred_taken;
    logic        rdy;
    logic        allow;
    logic        drop;
    logic        flush;
    logic        redir_vld;
    logic [31:0] redir_pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: counters as plain integers, the mispredict episode as
  // "busy" (waiting for redirect) and "offer" (redirect being presented).
  int          m_bht[64];
  int          m_cnt;
  bit          m_busy;
  bit          m_offer;
  logic [31:0] m_target;

  function automatic int bht_idx(logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_cnt    = 0;
    m_busy   = 0;
    m_offer  = 0;
    m_target = '0;
    redir_q.delete();
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Called with inputs already driven: predict this cycle's outputs, then
  // advance the model across the coming clock edge.
  task automatic step();
    exp_t e;
    bit   acc;
    bit   mis;
    int   old_cnt;
    int   i;
    acc         = ex_rsp.vld && !m_busy;
    mis         = acc && !ex_rsp.pkt.pred_true;
    e.rdy       = !m_busy;
    e.flush     = mis;
    e.drop      = m_busy || mis;
    e.allow     = !m_busy && !mis && (m_cnt < MAX_OUT);
    e.pred_taken = (m_bht[bht_idx(pred_pc)] >= 2);
    e.redir_vld = m_busy && m_offer;
    e.redir_pc  = m_target;
    exp_q.push_back(e);
    if (!rst_n) begin
      model_reset();
    end else begin
      old_cnt = m_cnt;
      if (acc) begin
        i = bht_idx(ex_rsp.pkt.pc);
        if (ex_rsp.pkt.taken) m_bht[i] = (m_bht[i] < 3) ? m_bht[i] + 1 : 3;
        else                  m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
      end
      m_cnt = m_cnt + int'(fch_req_fire) - int'(fch_rsp_fire);
      if (mis) begin
        m_busy   = 1;
        m_offer  = 0;
        m_target = ex_rsp.pkt.target_pc;
        redir_q.push_back(ex_rsp.pkt.target_pc);
      end else if (m_busy && !m_offer && old_cnt == 0) begin
        m_offer = 1;
      end else if (m_busy && m_offer && redir_rdy) begin
        m_busy  = 0;
        m_offer = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic vld, input logic [31:0] pc,
                                input logic [31:0] tgt, input logic taken,
                                input logic pred_true, input logic req,
                                input logic rsp, input logic rrdy,
                                input logic rstn);
    ex_rsp.vld           = vld;
    ex_rsp.pkt.pc        = pc;
    ex_rsp.pkt.target_pc = tgt;
    ex_rsp.pkt.taken     = taken;
    ex_rsp.pkt.pred_true = pred_true;
    fch_req_fire         = req;
    fch_rsp_fire         = rsp;
    redir_rdy            = rrdy;
    rst_n                = rstn;
    step();
  endtask

  task automatic idle(int n, logic rrdy);
    repeat (n) apply_stimulus(0, 0, 0, 0, 1, 0, 0, rrdy, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] want;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("pred_taken", 32'(pred_taken), 32'(e.pred_taken));
      check_output("ex_rsp_rdy", 32'(ex_rsp.rdy), 32'(e.rdy));
      check_output("fch_req_allow", 32'(fch_req_allow), 32'(e.allow));
      check_output("fch_rsp_drop", 32'(fch_rsp_drop), 32'(e.drop));
      check_output("flush", 32'(flush), 32'(e.flush));
      check_output("redir_vld", 32'(redir_vld), 32'(e.redir_vld));
      check_output("redir_pc", redir_pc, e.redir_pc);
      if (redir_vld && redir_rdy) begin
        if (redir_q.size() == 0) begin
          check_output("redirect_unexpected", 32'(1), 32'(0));
        end else begin
          want = redir_q.pop_front();
          check_output("redirect_target", redir_pc, want);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pred_pc = '0;
    ex_rsp.vld = 1'b0;
    ex_rsp.pkt = '0;
    fch_req_fire = 1'b0;
    fch_rsp_fire = 1'b0;
    redir_rdy = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset state with pred_pc 0x100, then three taken trainings to saturation.
    pred_pc = 32'h100;
    idle(1, 1);
    repeat (3) apply_stimulus(1, 32'h100, 32'h0, 1, 1, 0, 0, 1, 1);
    idle(1, 1);

    // Two outstanding fetches, mispredict, wrong-path responses at T+1, T+3.
    repeat (2) apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 1);
    apply_stimulus(1, 32'h200, 32'h340, 1, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1, 1);
    idle(4, 1);

    // Mispredict with nothing outstanding and a slow PC generator.
    apply_stimulus(1, 32'h104, 32'h880, 0, 0, 0, 0, 0, 1);
    idle(4, 0);
    idle(3, 1);

    // Concurrent request/response while draining leaves the count unchanged.
    apply_stimulus(0, 0, 0, 0, 1, 1, 0, 1, 1);
    apply_stimulus(1, 32'h208, 32'h5c0, 1, 0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 1, 1, 1);
    idle(3, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 1, 1, 1);
    idle(4, 1);

    // Reset while presenting a redirect aborts it and restores the BHT.
    apply_stimulus(1, 32'h100, 32'h9a0, 0, 0, 0, 0, 0, 1);
    idle(3, 0);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(2, 1);
    apply_stimulus(1, 32'h100, 32'h0, 1, 1, 0, 0, 1, 1);
    idle(1, 1);

    // Random traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      logic        rstn;
      logic        vld;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        req;
      logic        rsp;
      logic        rrdy;
      rstn = ($urandom_range(0, 299) != 0);
      vld  = ($urandom_range(0, 2) == 0);
      pc   = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      tgt  = {$urandom(), 2'b00} & 32'hffff_fffc;
      req  = (m_cnt < MAX_OUT) && ($urandom_range(0, 1) == 1);
      rsp  = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
      rrdy = ($urandom_range(0, 1) == 1);
      if (!rstn) begin
        vld  = 0;
        req  = 0;
        rsp  = 0;
        rrdy = 0;
      end
      pred_pc = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
      apply_stimulus(vld, pc, tgt, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) != 0, req, rsp, rrdy, rstn);
    end
    idle(2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
